// File: rtl/shared_datamemory.sv
module shared_datamemory #(
    parameter int DATA_W     = 12,
    parameter int BUS_W      = 17,
    parameter int ADDR_W     = 12,
    parameter int NUM_CORES  = 2,
    parameter     INIT_FILE  = "",
    parameter int TAP_BASE   = 4,
    parameter int TAP_ROWS   = 4,
    parameter int TAP_COLS   = 4,
    parameter int TAP_STRIDE = 64,
    localparam int TAP_N     = TAP_ROWS * TAP_COLS,
    localparam int IDX_W     = (TAP_N > 1) ? $clog2(TAP_N) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*BUS_W-1:0]  datain,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [NUM_CORES*DATA_W-1:0] dataout,
    input  logic                        tap_start,
    output logic                        tap_busy,
    output logic                        tap_valid,
    output logic [DATA_W-1:0]           tap_data,
    output logic [IDX_W-1:0]            tap_idx,
    output logic                        tap_done
);
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(TAP_ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(TAP_COLS - 1);

    typedef enum logic {TAP_IDLE, TAP_SCAN} tap_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]            cand, gidx;
    logic                        granted;
    logic [NUM_CORES-1:0]        gnt_c;
    logic [NUM_CORES-1:0]        rvalid_q, rvalid_d;
    logic [NUM_CORES*DATA_W-1:0] dataout_q, dataout_d;

    logic [ADDR_W-1:0] core_addr, tap_addr, ram_addr;
    logic [DATA_W-1:0] core_wdata, rd_word;
    logic              core_we, ram_we, tap_issue, tap_last;

    tap_state_t        state_q, state_d;
    logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0]  tap_idx_q, tap_idx_d;
    logic [DATA_W-1:0] tap_data_q, tap_data_d;
    logic              tap_busy_q, tap_busy_d;
    logic              tap_valid_q, tap_valid_d;
    logic              tap_done_q, tap_done_d;

    always_comb begin
        gnt_c   = '0;
        granted = 1'b0;
        gidx    = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_CORES);
            if (!granted && req[cand]) begin
                gnt_c[cand] = 1'b1;
                granted     = 1'b1;
                gidx        = cand;
            end
        end
        if (rst) begin
            gnt_c   = '0;
            granted = 1'b0;
        end
        rr_ptr_d = granted ? PTR_W'((int'(gidx) + 1) % NUM_CORES) : rr_ptr_q;
    end

    assign gnt = gnt_c;

    always_comb begin
        core_addr  = addr[int'(gidx)*ADDR_W +: ADDR_W];
        core_wdata = datain[int'(gidx)*BUS_W +: DATA_W];
        core_we    = we[gidx];
        tap_addr   = ADDR_W'(32'(TAP_BASE) + 32'(row_q) * 32'(TAP_STRIDE) + 32'(col_q));
        tap_issue  = (state_q == TAP_SCAN) && (req == '0) && !rst;
        ram_addr   = granted ? core_addr : tap_addr;
        ram_we     = granted && core_we;
        rvalid_d   = '0;
        dataout_d  = dataout_q;
        if (granted && !core_we) begin
            rvalid_d[gidx]                          = 1'b1;
            dataout_d[int'(gidx)*DATA_W +: DATA_W]  = rd_word;
        end
    end

    assign rd_word = mem[ram_addr];

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= core_wdata;
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        tap_valid_d = 1'b0;
        tap_done_d  = 1'b0;
        tap_data_d  = tap_data_q;
        tap_idx_d   = tap_idx_q;
        tap_last    = (row_q == LAST_ROW) && (col_q == LAST_COL);
        case (state_q)
            TAP_IDLE: begin
                if (tap_start) begin
                    state_d = TAP_SCAN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            TAP_SCAN: begin
                if (tap_issue) begin
                    tap_valid_d = 1'b1;
                    tap_done_d  = tap_last;
                    tap_data_d  = rd_word;
                    tap_idx_d   = IDX_W'(32'(row_q) * 32'(TAP_COLS) + 32'(col_q));
                    if (tap_last) begin
                        state_d = TAP_IDLE;
                    end else if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = TAP_IDLE;
        endcase
        tap_busy_d = (state_d == TAP_SCAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            rvalid_q    <= '0;
            dataout_q   <= '0;
            state_q     <= TAP_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            tap_busy_q  <= 1'b0;
            tap_valid_q <= 1'b0;
            tap_done_q  <= 1'b0;
            tap_data_q  <= '0;
            tap_idx_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rvalid_q    <= rvalid_d;
            dataout_q   <= dataout_d;
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tap_busy_q  <= tap_busy_d;
            tap_valid_q <= tap_valid_d;
            tap_done_q  <= tap_done_d;
            tap_data_q  <= tap_data_d;
            tap_idx_q   <= tap_idx_d;
        end
    end

    assign rvalid    = rvalid_q;
    assign dataout   = dataout_q;
    assign tap_busy  = tap_busy_q;
    assign tap_valid = tap_valid_q;
    assign tap_done  = tap_done_q;
    assign tap_data  = tap_data_q;
    assign tap_idx   = tap_idx_q;

endmodule

// File: tb/tb_shared_datamemory.sv
// Scoreboard bench for shared_datamemory: a bench-side arbiter/RAM/tap model
// queues expected read and tap results, compared when the DUT produces them.
module tb_shared_datamemory;
    localparam int DW = 12;
    localparam int BW = 17;
    localparam int AW = 12;
    localparam int NC = 2;
    localparam int TBASE = 4;
    localparam int TSTR  = 64;

    typedef struct { int core; logic [DW-1:0] data; } rd_exp_t;
    typedef struct { logic [3:0] idx; logic [DW-1:0] data; logic done; } tap_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance (4x4 window at base 4)
    logic [NC-1:0]    req, we, gnt, rvalid;
    logic [NC*AW-1:0] addr;
    logic [NC*BW-1:0] datain;
    logic [NC*DW-1:0] dataout;
    logic             tap_start, tap_busy, tap_valid, tap_done;
    logic [DW-1:0]    tap_data;
    logic [3:0]       tap_idx;

    // wrap instance (2x2 window at base 4090)
    logic [NC-1:0]    w_req, w_we, w_gnt, w_rvalid;
    logic [NC*AW-1:0] w_addr;
    logic [NC*BW-1:0] w_datain;
    logic [NC*DW-1:0] w_dataout;
    logic             w_tap_start, w_tap_busy, w_tap_valid, w_tap_done;
    logic [DW-1:0]    w_tap_data;
    logic [1:0]       w_tap_idx;

    shared_datamemory #(.DATA_W(DW), .BUS_W(BW), .ADDR_W(AW), .NUM_CORES(NC),
        .TAP_BASE(TBASE), .TAP_ROWS(4), .TAP_COLS(4), .TAP_STRIDE(TSTR)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .datain(datain),
        .gnt(gnt), .rvalid(rvalid), .dataout(dataout), .tap_start(tap_start),
        .tap_busy(tap_busy), .tap_valid(tap_valid), .tap_data(tap_data),
        .tap_idx(tap_idx), .tap_done(tap_done));

    shared_datamemory #(.DATA_W(DW), .BUS_W(BW), .ADDR_W(AW), .NUM_CORES(NC),
        .TAP_BASE(4090), .TAP_ROWS(2), .TAP_COLS(2), .TAP_STRIDE(64)) u_dut_w (
        .clk(clk), .rst(rst), .req(w_req), .we(w_we), .addr(w_addr), .datain(w_datain),
        .gnt(w_gnt), .rvalid(w_rvalid), .dataout(w_dataout), .tap_start(w_tap_start),
        .tap_busy(w_tap_busy), .tap_valid(w_tap_valid), .tap_data(w_tap_data),
        .tap_idx(w_tap_idx), .tap_done(w_tap_done));

    int checks = 0;
    int failures = 0;

    // bench model state
    logic [DW-1:0] mm [4096];
    int            rr = 0;
    logic          tscan = 1'b0;
    int            trow = 0, tcol = 0;
    rd_exp_t       cq[$];
    tap_exp_t      tq[$];
    int            nvalid = 0, nbusy = 0;
    int            nrv0 = 0, nrv1 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_gnt"},       32'(gnt), 32'd0);
        chk({tag, "_rvalid"},    32'(rvalid), 32'd0);
        chk({tag, "_dataout"},   32'(dataout), 32'd0);
        chk({tag, "_tap_busy"},  32'(tap_busy), 32'd0);
        chk({tag, "_tap_valid"}, 32'(tap_valid), 32'd0);
        chk({tag, "_tap_done"},  32'(tap_done), 32'd0);
        chk({tag, "_tap_data"},  32'(tap_data), 32'd0);
        chk({tag, "_tap_idx"},   32'(tap_idx), 32'd0);
    endtask

    // One clock: predict grant/tap issue, let the edge happen, compare outputs.
    task automatic step();
        logic [NC-1:0] eg, erv;
        int            gc, c, ta;
        logic [AW-1:0] a;
        logic          was_scan, tlast;
        rd_exp_t       re;
        tap_exp_t      te;
        #1;
        eg = '0; erv = '0; gc = -1;
        if (!rst) begin
            for (int i = 0; i < NC; i++) begin
                c = (rr + i) % NC;
                if (gc < 0 && req[c]) gc = c;
            end
        end
        if (gc >= 0) eg[gc] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        was_scan = tscan;
        if (gc >= 0) begin
            a  = addr[gc*AW +: AW];
            rr = (gc + 1) % NC;
            if (we[gc]) mm[a] = datain[gc*BW +: DW];
            else begin
                erv[gc] = 1'b1;
                re.core = gc; re.data = mm[a];
                cq.push_back(re);
            end
        end else if (!rst && was_scan) begin
            ta      = (TBASE + trow*TSTR + tcol) % 4096;
            tlast   = (trow == 3) && (tcol == 3);
            te.idx  = 4'(trow*4 + tcol);
            te.data = mm[12'(ta)];
            te.done = tlast;
            tq.push_back(te);
            if (tlast) tscan = 1'b0;
            else if (tcol == 3) begin tcol = 0; trow++; end
            else tcol++;
        end
        if (!rst && !was_scan && tap_start) begin
            tscan = 1'b1; trow = 0; tcol = 0;
        end
        @(posedge clk); #1;
        chk("rvalid", 32'(rvalid), 32'(erv));
        if (rvalid[0]) nrv0++;
        if (rvalid[1]) nrv1++;
        if (cq.size() > 0) begin
            re = cq.pop_front();
            chk("dataout", 32'(dataout[re.core*DW +: DW]), 32'(re.data));
        end
        chk("tap_valid", 32'(tap_valid), 32'(tq.size() > 0));
        if (tq.size() > 0) begin
            te = tq.pop_front();
            chk("tap_data", 32'(tap_data), 32'(te.data));
            chk("tap_idx",  32'(tap_idx),  32'(te.idx));
            chk("tap_done", 32'(tap_done), 32'(te.done));
            nvalid++;
        end else begin
            chk("tap_done_idle", 32'(tap_done), 32'd0);
        end
        chk("tap_busy", 32'(tap_busy), 32'(tscan));
        if (tap_busy) nbusy++;
        @(negedge clk);
    endtask

    task automatic core_op(input int core, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
        req = '0; we = '0;
        req[core] = 1'b1;
        we[core]  = w;
        addr[core*AW +: AW]   = a;
        datain[core*BW +: BW] = d;
        step();
        req = '0; we = '0;
    endtask

    task automatic run_scan_idle(input int budget);
        for (int i = 0; i < budget && (tscan || tq.size() > 0); i++) step();
    endtask

    initial begin
        logic [DW-1:0] wexp [4];
        int k;
        rst = 1'b1;
        req = '0; we = '0; addr = '0; datain = '0; tap_start = 1'b0;
        w_req = '0; w_we = '0; w_addr = '0; w_datain = '0; w_tap_start = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        // preload the 4x4 window alternating cores
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                core_op((r + c) % 2, 1'b1, AW'(TBASE + r*TSTR + c), BW'($urandom));

        // write then read-back, upper bus bits dropped
        core_op(0, 1'b1, 12'd5, 17'h1_0ABC);
        core_op(0, 1'b0, 12'd5, 17'h0);
        chk("t1_data", 32'(dataout[DW-1:0]), 32'h0ABC);

        // make core0 next in line, then contend for 4 cycles
        core_op(1, 1'b0, 12'd68, 17'h0);
        nrv0 = 0; nrv1 = 0;
        req = 2'b11; we = 2'b00;
        addr[0 +: AW] = 12'd5; addr[AW +: AW] = 12'd68;
        repeat (4) step();
        req = '0;
        step();
        chk("t2_rv0", 32'(nrv0), 32'd2);
        chk("t2_rv1", 32'(nrv1), 32'd2);

        // full scan with a silent bus
        nvalid = 0; nbusy = 0;
        tap_start = 1'b1; step(); tap_start = 1'b0;
        run_scan_idle(40);
        chk("t3_nvalid", 32'(nvalid), 32'd16);
        chk("t3_nbusy", 32'(nbusy), 32'd16);

        // scan while core1 hammers every other cycle, writing a not-yet-read element
        nvalid = 0;
        tap_start = 1'b1; step(); tap_start = 1'b0;
        for (int i = 0; i < 80 && (tscan || tq.size() > 0); i++) begin
            req = '0; we = '0;
            if (i % 2 == 0) begin
                req[1] = 1'b1;
                we[1]  = (i % 4 == 0);
                addr[AW +: AW]   = (i % 4 == 0) ? 12'd199 : 12'd4;
                datain[BW +: BW] = BW'(17'h100 + i);
            end
            step();
        end
        req = '0; we = '0;
        chk("t4_nvalid", 32'(nvalid), 32'd16);

        // abort mid-scan with reset, then rescan from idx 0
        nvalid = 0;
        tap_start = 1'b1; step(); tap_start = 1'b0;
        for (int i = 0; i < 20 && nvalid < 7; i++) step();
        chk("t5_reached7", 32'(nvalid), 32'd7);
        rst = 1'b1;
        #1;
        chk_zero_outputs("t5_rst");
        cq.delete(); tq.delete(); tscan = 1'b0; rr = 0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        repeat (3) step();
        chk("t5_no_valid", 32'(nvalid), 32'd0);
        tap_start = 1'b1; step(); tap_start = 1'b0;
        run_scan_idle(40);
        chk("t5_rescan", 32'(nvalid), 32'd16);

        // wrap instance: window 4090,4091,58,59
        wexp[0] = 12'h111; wexp[1] = 12'h222; wexp[2] = 12'h333; wexp[3] = 12'h444;
        for (int i = 0; i < 4; i++) begin
            w_req = 2'b01; w_we = 2'b01;
            w_addr[0 +: AW] = (i == 0) ? 12'd4090 : (i == 1) ? 12'd4091 : (i == 2) ? 12'd58 : 12'd59;
            w_datain[0 +: BW] = BW'(wexp[i]);
            @(negedge clk);
        end
        w_req = '0; w_we = '0;
        w_tap_start = 1'b1; @(negedge clk); w_tap_start = 1'b0;
        k = 0;
        for (int i = 0; i < 20 && k < 4; i++) begin
            @(posedge clk); #1;
            if (w_tap_valid) begin
                chk("t6_data", 32'(w_tap_data), 32'(wexp[k]));
                chk("t6_idx",  32'(w_tap_idx),  32'(k));
                chk("t6_done", 32'(w_tap_done), 32'(k == 3));
                k++;
            end
        end
        chk("t6_count", 32'(k), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
